// File: rtl/unsat_clause_picker.sv
// unsat_clause_picker: drains the clause FIFO tree once per start, keeps the
// entry reached after an LFSR-chosen skip count, clears the tree overflow flag
// and hands the chosen clause (or a "formula satisfied" flag) downstream.
module unsat_clause_picker #(
    parameter int          CLAUSE_WIDTH  = 36,
    parameter int          SETTLE_CYCLES = 4,
    parameter int          SKIP_BITS     = 3,
    parameter logic [15:0] SEED          = 16'h0001,
    parameter bit          DRAIN_REST    = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic                    empty_i,
    input  logic                    of_i,
    input  logic [CLAUSE_WIDTH-1:0] clause_i,
    output logic                    rden_o,
    output logic                    cof_o,
    output logic                    busy_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [CLAUSE_WIDTH-1:0] clause_o,
    output logic                    sat_o,
    output logic                    of_o,
    output logic [SKIP_BITS:0]      popped_o
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_POP,
        S_CAPTURE,
        S_DRAIN,
        S_CLEAR,
        S_OUT
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [15:0]             lfsr;
    logic [15:0]             lfsr_nxt;
    logic [SKIP_BITS-1:0]    tgt;
    logic [SKIP_BITS:0]      cnt;
    logic [SKIP_BITS:0]      cnt_inc;
    logic [SKIP_BITS:0]      tgt_last;
    logic                    pick_done;
    logic [SW-1:0]           settle_cnt;
    logic                    of_seen;
    logic                    sat_q;
    logic [CLAUSE_WIDTH-1:0] clause_q;

    // One step of the 16-bit Galois LFSR (right shift, taps 16'hB400).
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        lfsr_step = cur[0] ? ((cur >> 1) ^ 16'hB400) : (cur >> 1);
    endfunction

    assign lfsr_nxt  = lfsr_step(lfsr);
    assign cnt_inc   = cnt + 1'b1;
    assign tgt_last  = {1'b0, tgt} + 1'b1;
    // Stop on the skip target, or earlier if the tree ran dry: the entry
    // just captured is then the pick.
    assign pick_done = (cnt_inc == tgt_last) || empty_i;

    assign clause_o = clause_q;
    assign sat_o    = sat_q;
    assign of_o     = of_seen;
    assign popped_o = cnt;

    // State register; reset aborts any round in progress without a cOF pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the tree/downstream strobes derived from state.
    always_comb begin
        state_nxt = state;
        rden_o    = 1'b0;
        cof_o     = 1'b0;
        valid_o   = 1'b0;
        busy_o    = 1'b1;
        case (state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = empty_i ? S_CLEAR : S_POP;
                end
            end
            S_POP: begin
                rden_o    = 1'b1;
                state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (pick_done) begin
                    state_nxt = DRAIN_REST ? S_DRAIN : S_CLEAR;
                end else begin
                    state_nxt = S_POP;
                end
            end
            S_DRAIN: begin
                // Gate the read with empty so the tree is never popped dry.
                rden_o = ~empty_i;
                if (empty_i) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cof_o     = 1'b1;
                state_nxt = S_OUT;
            end
            S_OUT: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Round bookkeeping: LFSR/target on start, settle timer, pick capture,
    // sticky overflow and the result registers held through OUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr       <= SEED;
            tgt        <= '0;
            cnt        <= '0;
            settle_cnt <= '0;
            of_seen    <= 1'b0;
            sat_q      <= 1'b0;
            clause_q   <= '0;
        end else begin
            if (state inside {S_SETTLE, S_POP, S_CAPTURE, S_DRAIN, S_CLEAR}) begin
                of_seen <= of_seen | of_i;
            end
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        settle_cnt <= SW'(SETTLE_CYCLES);
                        lfsr       <= lfsr_nxt;
                        tgt        <= lfsr_nxt[SKIP_BITS-1:0];
                        cnt        <= '0;
                        of_seen    <= 1'b0;
                        sat_q      <= 1'b0;
                        clause_q   <= '0;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        sat_q <= empty_i;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    clause_q <= clause_i;
                    cnt      <= cnt_inc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/unsat_clause_picker.md
Name: unsat_clause_picker

Overview:
- Sits directly downstream of the clause FIFO tree in the WalkSAT pipeline.
- On each `start_i`, pops unsatisfied clauses from the tree and selects one pseudo-randomly by skipping an LFSR-chosen number of entries.
- Drains the rest of the tree, clears its overflow flag, and presents the chosen clause to the flip/break-value stage with a valid/ready handshake.
- Reports "no unsatisfied clause" (formula satisfied) when the tree stays empty.

Parameters:
- CLAUSE_WIDTH, 36, width of one clause word; must match the FIFO tree.
- SETTLE_CYCLES, 4, cycles waited after start for data to sift to the tree output (≥1).
- SKIP_BITS, 3, number of LFSR bits used as skip count; max skip is 2^SKIP_BITS−1.
- SEED, 16'h0001, LFSR reset value; must be nonzero.
- DRAIN_REST, 1, 1 = drain remaining entries after the pick; 0 = leave them in the tree.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  begin one selection round; honoured only in IDLE.
- empty_i  in  1  FIFO tree `empty`.
- of_i  in  1  FIFO tree `OF` (overflow).
- clause_i  in  CLAUSE_WIDTH  FIFO tree `clause_o`; valid the cycle after `rden_o`.
- rden_o  out  1  FIFO tree `rden`.
- cof_o  out  1  FIFO tree `cOF`; one-cycle pulse.
- busy_o  out  1  high in every state except IDLE.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- clause_o  out  CLAUSE_WIDTH  picked clause.
- sat_o  out  1  with `valid_o`: tree was empty, no clause picked.
- of_o  out  1  with `valid_o`: `of_i` was seen high during the round.
- popped_o  out  SKIP_BITS+1  number of entries popped before the pick stopped.

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-high, port `reset`.
- Reset values:
  - State IDLE; `lfsr` = SEED.
  - `rden_o`, `cof_o`, `busy_o`, `valid_o`, `sat_o`, `of_o` = 0.
  - `clause_o` = 0; `popped_o` = 0.
- Reset mid-round aborts immediately; no `cof_o` pulse is issued.
- LFSR: 16-bit Galois, right shift, tap mask 16'hB400: if lsb=1, `next = (lfsr>>1)^16'hB400`, else `next = lfsr>>1`.
  - Advances exactly once per accepted start.
  - Skip target `tgt = next[SKIP_BITS-1:0]`, latched at start.
- States:
  - IDLE: on `start_i`, load settle counter = SETTLE_CYCLES, advance LFSR, latch `tgt`, clear `cnt` and sticky OF → SETTLE.
  - SETTLE: decrement counter; when it reaches 0, sample `empty_i`.
    - `empty_i`=1 → `sat_o`=1, go to CLEAR.
    - else → POP.
  - POP: `rden_o`=1 for exactly one cycle → CAPTURE.
  - CAPTURE: register `clause_i` into `clause_o`; `cnt = cnt+1`.
    - If `cnt == tgt+1` or `empty_i`=1: DRAIN if DRAIN_REST=1, else CLEAR.
    - Otherwise → POP.
    - Early empty means the last captured entry is the pick (skip saturates).
  - DRAIN: `rden_o = ~empty_i` (combinational gate, never reads while empty); `empty_i`=1 → CLEAR. Drained data is discarded.
  - CLEAR: `cof_o`=1 for one cycle → OUT.
  - OUT: `valid_o`=1; `clause_o`, `sat_o`, `of_o`, `popped_o` held stable until `ready_i`. On `valid_o && ready_i` → IDLE and `valid_o` falls next cycle.
- `of_o` is sticky OR of `of_i` from SETTLE through CLEAR; a pulse in CLEAR still counts.
- `popped_o` = `cnt`; it is 0 when `sat_o`=1.
- When `sat_o`=1, `clause_o` = 0.
- `start_i` outside IDLE is ignored and the LFSR does not advance.
- `start_i` in the same cycle as OUT→IDLE is ignored; it is only seen in IDLE.
- Minimum latency from start to `valid_o` with a non-empty tree, no drain: SETTLE_CYCLES + 2·(tgt+1) + 2 cycles.
- `rden_o` is never high in IDLE, SETTLE, CAPTURE, CLEAR or OUT.

Test Plan:
- Empty result: SEED=1, tree empty, start → after 4 settle cycles, `cof_o` pulses once, then `valid_o`=1 with `sat_o`=1, `popped_o`=0, `clause_o`=0; `rden_o` never high.
- First entry picked: SEED=1, tree loaded with 5 clauses A..E → LFSR=16'hB400, `tgt`=0, pick=A, `popped_o`=1. DRAIN reads B..E (4 `rden_o` cycles), then `cof_o`, then `valid_o`.
- Skip: SEED=16'h0007, tree holds 6 clauses → `tgt`=3, pick = 4th clause, `popped_o`=4. The next round's LFSR=16'hEE01 gives `tgt`=1.
- Early empty and overflow: SEED=7, tree holds 2 clauses, `of_i` pulsed one cycle mid-round → pick = 2nd clause, `popped_o`=2, `of_o`=1. No `rden_o` is issued while `empty_i`=1.
- Backpressure and ignored start: hold `ready_i`=0 for 10 cycles with `start_i` pulsed during OUT → outputs stable, LFSR unchanged. Raise `ready_i` → IDLE next cycle.
- Reset mid-DRAIN: assert `reset` for 1 cycle → next cycle IDLE, all outputs 0, LFSR = SEED, no `cof_o`.
